// File: rtl/lpf_pkg.sv
// Shared types and helpers for the multi-channel running-average low-pass.
package lpf_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    localparam int DRAIN_CYCLES = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int clamp_sel(input int sel, input int max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

endpackage

// File: rtl/lpf_hist_ram.sv
// Per-channel sample history: simple dual-port RAM, 1-cycle read,
// write-first bypass when the read hits the word being written.
module lpf_hist_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/multich_avg_lpf.sv
// Time-multiplexed running-average low-pass, length 2^sel per channel,
// with history flush on every length change.
module multich_avg_lpf
    import lpf_pkg::*;
#(
    parameter int DATA_W        = 24,
    parameter int LOG2_MAX_TAPS = 4,
    parameter int CHANNELS      = 2,
    parameter int SEL_W         = clog2(LOG2_MAX_TAPS + 1),
    parameter int CH_W          = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1,
    parameter int ACC_W         = DATA_W + LOG2_MAX_TAPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  filt_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] d,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] q,
    output logic [SEL_W-1:0]  active_sel,
    output logic              busy
);

    localparam int TAPS   = 1 << LOG2_MAX_TAPS;
    localparam int DEPTH  = CHANNELS * TAPS;
    localparam int PTR_W  = LOG2_MAX_TAPS;
    localparam int ADDR_W = CH_W + PTR_W;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [1:0]        drain_cnt;
    logic [SEL_W-1:0]  req_sel;

    logic              take;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wptr [CHANNELS];
    logic signed [ACC_W-1:0] acc [CHANNELS];

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [PTR_W-1:0]  s1_ptr;
    logic [DATA_W-1:0] s1_x;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] oldest;

    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W:0]   rounded;
    logic [DATA_W-1:0]       q_next;

    assign req_sel = SEL_W'(clamp_sel(int'(filt_sel), LOG2_MAX_TAPS));
    assign take    = in_valid && in_ready && (32'(in_ch) < CHANNELS);
    assign rd_ptr  = wptr[in_ch] - (PTR_W'(1) << active_sel);

    // Sample writes land one cycle after the read; the RAM bypass covers L=1.
    assign ram_we    = (state == CLEAR) || s1_valid;
    assign ram_waddr = (state == CLEAR) ? clr_addr : {s1_ch, s1_ptr};
    assign ram_wdata = (state == CLEAR) ? '0 : s1_x;

    lpf_hist_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({in_ch, rd_ptr}),
        .rdata (oldest)
    );

    assign acc_next = acc[s1_ch]
                    + {{LOG2_MAX_TAPS{s1_x[DATA_W-1]}}, s1_x}
                    - {{LOG2_MAX_TAPS{oldest[DATA_W-1]}}, oldest};
    assign rounded  = {acc_next[ACC_W-1], acc_next}
                    + ((ACC_W+1)'(1) << active_sel >> 1);
    assign q_next   = DATA_W'(rounded >>> active_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            drain_cnt  <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            active_sel <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        active_sel <= req_sel;
                        busy       <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (req_sel != active_sel) begin
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        clr_addr <= '0;
                        state    <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wptr[i] <= '0;
                acc[i]  <= '0;
            end
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_ptr    <= '0;
            s1_x      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            q         <= '0;
        end else begin
            s1_valid  <= take;
            out_valid <= s1_valid;
            if (take) begin
                s1_ch  <= in_ch;
                s1_ptr <= wptr[in_ch];
                s1_x   <= d;
            end
            if (s1_valid) begin
                out_ch <= s1_ch;
                q      <= q_next;
            end
            if (state == CLEAR) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    wptr[i] <= '0;
                    acc[i]  <= '0;
                end
            end else begin
                if (take) wptr[in_ch] <= wptr[in_ch] + PTR_W'(1);
                if (s1_valid) acc[s1_ch] <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_multich_avg_lpf.sv
// Directed bench for multich_avg_lpf: flush timing, latency, rounding,
// channel isolation, full-scale extremes and mid-flush reset.
module tb_multich_avg_lpf;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         filt_sel;
    logic               in_valid;
    logic               in_ready;
    logic [0:0]         in_ch;
    logic signed [23:0] d;
    logic               out_valid;
    logic [0:0]         out_ch;
    logic signed [23:0] q;
    logic [2:0]         active_sel;
    logic               busy;

    typedef struct {
        int ch;
        int q;
        int cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  last_cyc = 0;
    int  out_cyc = 0;

    always #5 clk = ~clk;

    multich_avg_lpf dut (
        .clk        (clk),
        .reset      (reset),
        .filt_sel   (filt_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .d          (d),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .q          (q),
        .active_sel (active_sel),
        .busy       (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_valid)
            evq.push_back('{ch: int'(out_ch), q: int'(q), cyc: cyc});

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int s, input int exp);
        int n;
        n = 0;
        filt_sel = 3'(s);
        tick();
        while (!in_ready && n < 200) begin
            n++;
            tick();
        end
        chk("sel_ready", int'(in_ready), 1);
        chk("sel_active", int'(active_sel), exp);
    endtask

    task automatic send(input int ch, input int x);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            tick();
        end
        if (!in_ready) chk("send_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_ch    = 1'(ch);
        d        = 24'(x);
        last_cyc = cyc;
        tick();
    endtask

    task automatic get_out(input string tag, output int ch, output int val);
        int n;
        n = 0;
        ch = -1;
        val = 0;
        while (evq.size() == 0 && n < 50) begin
            n++;
            tick();
        end
        if (evq.size() == 0) begin
            chk({tag, "_timeout"}, evq.size(), 1);
        end else begin
            ch      = evq[0].ch;
            val     = evq[0].q;
            out_cyc = evq[0].cyc;
            evq.delete(0);
        end
    endtask

    task automatic expect_out(input string tag, input int ch, input int val);
        int gch;
        int gval;
        get_out(tag, gch, gval);
        chk({tag, "_ch"}, gch, ch);
        chk(tag, gval, val);
    endtask

    initial begin
        int n;
        int rdy_seen;
        int sent;
        int m;
        int gch;
        int gval;

        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rdy_seen;
        int sent;
        int m;
        int gch;
        int gval;

        // reset state, then first CLEAR with in_valid held high
        reset    = 1'b1;
        filt_sel = 3'd2;
        in_valid = 1'b1;
        in_ch    = 1'b0;
        d        = '0;
        repeat (3) tick();
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_active_sel", int'(active_sel), 0);
        chk("rst_busy", int'(busy), 1);

        reset = 1'b0;
        n = 0;
        rdy_seen = 0;
        while (busy && n < 100) begin
            if (in_ready) rdy_seen = 1;
            n++;
            tick();
        end
        chk("clr_cycles", n, 32);
        chk("clr_no_ready", rdy_seen, 0);
        chk("clr_active_sel", int'(active_sel), 2);
        chk("run0_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        chk("run1_ready", int'(in_ready), 1);
        chk("clr_no_out", evq.size(), 0);

        // pure delay, back-to-back on one channel
        set_sel(0, 0);
        send(0, 100);
        sent = last_cyc;
        send(0, -5);
        in_valid = 1'b0;
        get_out("t2_a", gch, gval);
        chk("t2_a_ch", gch, 0);
        chk("t2_a_q", gval, 100);
        chk("t2_latency", out_cyc, sent + 2);
        expect_out("t2_b", 0, -5);

        // two interleaved channels at length 4
        set_sel(2, 2);
        for (int k = 0; k < 8; k++) begin
            send(0, 1000);
            send(1, -400);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m = (k < 4) ? k + 1 : 4;
            expect_out("t3_c0", 0, 250 * m);
            expect_out("t3_c1", 1, -100 * m);
        end

        // length 2 rounding, then same length after a reflush
        set_sel(1, 1);
        send(0, 10);
        send(0, 20);
        send(0, 30);
        in_valid = 1'b0;
        expect_out("t4_a", 0, 5);
        expect_out("t4_b", 0, 15);
        expect_out("t4_c", 0, 25);
        set_sel(0, 0);
        set_sel(1, 1);
        send(0, 3);
        send(0, -3);
        send(0, -3);
        in_valid = 1'b0;
        expect_out("t4_d", 0, 2);
        expect_out("t4_e", 0, 0);
        expect_out("t4_f", 0, -3);

        // full-scale extremes at maximum length (sel=7 clamps to 4)
        set_sel(7, 4);
        for (int k = 0; k < 16; k++) send(0, -8388608);
        for (int k = 0; k < 16; k++) send(0, 8388607);
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            get_out("t5", gch, gval);
            if (k == 15) chk("t5_min", gval, -8388608);
            if (k == 23) chk("t5_mid", gval, 0);
            if (k == 31) chk("t5_max", gval, 8388607);
        end

        // length change while streaming
        set_sel(2, 2);
        for (int k = 0; k < 5; k++) send(0, 1000);
        filt_sel = 3'd3;
        send(0, 1000);
        in_valid = 1'b0;
        chk("t6_ready_drop", int'(in_ready), 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("t6_flush_cycles", n, 34);
        chk("t6_active_sel", int'(active_sel), 3);
        for (int k = 0; k < 6; k++) begin
            m = (k < 4) ? k + 1 : 4;
            expect_out("t6_old", 0, 250 * m);
        end
        send(0, 1000);
        in_valid = 1'b0;
        expect_out("t6_new", 0, 125);

        // reset in the middle of CLEAR
        filt_sel = 3'd1;
        tick();
        repeat (12) tick();
        chk("t6_mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_ready", int'(in_ready), 0);
        chk("t6_rst_busy", int'(busy), 1);
        chk("t6_rst_sel", int'(active_sel), 0);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        tick();
        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("t6_reclr_cycles", n, 32);
        chk("t6_reclr_sel", int'(active_sel), 1);
        chk("t6_no_stray_out", evq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
